// File: rtl/sobel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sobel_pkg
// Description : Shared widths, types, Sobel weights and the weighted
//               column/row sum helper used by the Sobel window stage.
// Revision    : 1.0 - initial release
// ============================================================================
package sobel_pkg;

    localparam int PIX_W  = 12;
    localparam int GRAD_W = 15;

    typedef logic        [PIX_W-1:0]  pix_t;
    typedef logic signed [GRAD_W-1:0] grad_t;

    // Sobel 1-2-1 smoothing weights along the axis orthogonal to the gradient.
    localparam logic [GRAD_W-1:0] c_W_EDGE = GRAD_W'(1);
    localparam logic [GRAD_W-1:0] c_W_MID  = GRAD_W'(2);

    function automatic logic [GRAD_W-1:0] zext(input pix_t p);
        return {{(GRAD_W-PIX_W){1'b0}}, p};
    endfunction

    // Weighted 1-2-1 sum of three pixels; the maximum of 4*4095 fits unsigned
    // in GRAD_W bits, so the later subtraction never overflows.
    function automatic logic [GRAD_W-1:0] wsum(input pix_t a, input pix_t b, input pix_t c);
        return (c_W_EDGE * zext(a)) + (c_W_MID * zext(b)) + (c_W_EDGE * zext(c));
    endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_line_tap.sv
`default_nettype none
// ============================================================================
// Module      : sobel_line_tap
// Description : Enable-gated fixed delay of DEPTH accepted samples, built as
//               a circular buffer (read-before-write at the same pointer).
// Ports       : i_clk  - clock
//               i_rst  - synchronous active-high reset (pointer only)
//               i_en   - shift enable (one accepted sample)
//               i_data - sample in
//               o_data - sample accepted DEPTH enables ago
// Revision    : 1.0 - initial release
// ============================================================================
module sobel_line_tap #(
    parameter int DEPTH = 640,
    parameter int W     = 12
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data
);

    localparam int                  c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_PTR_W-1:0]  c_LAST  = c_PTR_W'(DEPTH - 1);

    logic [W-1:0]       r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_ptr;

    // The slot under the pointer holds the oldest sample; it is read out
    // and overwritten by the incoming one on the same enable.
    assign o_data = r_mem[r_ptr];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (i_en) begin
            r_ptr <= (r_ptr == c_LAST) ? '0 : r_ptr + 1'b1;
        end
    end

    // Storage is deliberately not reset: stale contents only reach masked
    // border results.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            r_mem[r_ptr] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sobel_window_conv.sv
`default_nettype none
// ============================================================================
// Module      : sobel_window_conv
// Description : Raster 12-bit pixel stream -> 3x3 window -> signed Sobel
//               Gx/Gy, one result per accepted pixel, fixed 2-cycle latency.
// Ports       : iCLK    - pixel clock
//               iRST    - synchronous active-high reset
//               iDATA   - 12-bit unsigned pixel
//               iDVAL   - pixel valid (accept)
//               iFVAL   - frame valid; low holds row/col at 0
//               oSobelX - signed Gx (right minus left)
//               oSobelY - signed Gy (bottom minus top)
//               oDVAL   - one-cycle result strobe per accepted pixel
// Revision    : 1.0 - initial release
// ============================================================================
module sobel_window_conv
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic [PIX_W-1:0]         iDATA,
    input  logic                     iDVAL,
    input  logic                     iFVAL,
    output logic signed [GRAD_W-1:0] oSobelX,
    output logic signed [GRAD_W-1:0] oSobelY,
    output logic                     oDVAL
);

    // Both widths are at least 2 bits because both dimensions are >= 3.
    localparam int                  c_COL_W    = $clog2(IMG_WIDTH);
    localparam int                  c_ROW_W    = $clog2(IMG_HEIGHT);
    localparam logic [c_COL_W-1:0]  c_COL_LAST = c_COL_W'(IMG_WIDTH - 1);
    localparam logic [c_ROW_W-1:0]  c_ROW_LAST = c_ROW_W'(IMG_HEIGHT - 1);

    logic [c_COL_W-1:0] r_col;
    logic [c_ROW_W-1:0] r_row;
    pix_t               w_tap0;
    pix_t               w_tap1;
    pix_t               r_win [3][3];
    logic               r_v1;
    logic               r_border;
    logic               w_border;
    logic [GRAD_W-1:0]  w_gx;
    logic [GRAD_W-1:0]  w_gy;

    // Pixel coordinates -------------------------------------------------------
    always_ff @(posedge iCLK) begin
        if (iRST || !iFVAL) begin
            r_col <= '0;
            r_row <= '0;
        end else if (iDVAL) begin
            if (r_col == c_COL_LAST) begin
                r_col <= '0;
                r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Coordinate < 2 exactly when every bit above bit 0 is clear.
    assign w_border = ~|r_row[c_ROW_W-1:1] || ~|r_col[c_COL_W-1:1];

    // Line taps: one line above, then two lines above ---------------------------
    sobel_line_tap #(.DEPTH(IMG_WIDTH), .W(PIX_W)) u_tap0 (
        .i_clk  (iCLK),
        .i_rst  (iRST),
        .i_en   (iDVAL),
        .i_data (iDATA),
        .o_data (w_tap0)
    );

    sobel_line_tap #(.DEPTH(IMG_WIDTH), .W(PIX_W)) u_tap1 (
        .i_clk  (iCLK),
        .i_rst  (iRST),
        .i_en   (iDVAL),
        .i_data (w_tap0),
        .o_data (w_tap1)
    );

    // Stage 1: 3x3 window, column 2 is the newest -------------------------------
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_win    <= '{default: '0};
            r_v1     <= 1'b0;
            r_border <= 1'b0;
        end else begin
            r_v1 <= iDVAL;
            if (iDVAL) begin
                for (int r = 0; r < 3; r++) begin
                    r_win[r][0] <= r_win[r][1];
                    r_win[r][1] <= r_win[r][2];
                end
                r_win[0][2] <= w_tap1;
                r_win[1][2] <= w_tap0;
                r_win[2][2] <= iDATA;
                r_border    <= w_border;
            end
        end
    end

    // Stage 2: gradients ------------------------------------------------------
    assign w_gx = wsum(r_win[0][2], r_win[1][2], r_win[2][2])
                - wsum(r_win[0][0], r_win[1][0], r_win[2][0]);
    assign w_gy = wsum(r_win[2][0], r_win[2][1], r_win[2][2])
                - wsum(r_win[0][0], r_win[0][1], r_win[0][2]);

    // Outputs hold their last value across bubbles; border results are
    // still strobed so downstream sees one result per pixel.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oSobelX <= '0;
            oSobelY <= '0;
            oDVAL   <= 1'b0;
        end else begin
            oDVAL <= r_v1;
            if (r_v1) begin
                oSobelX <= r_border ? '0 : $signed(w_gx);
                oSobelY <= r_border ? '0 : $signed(w_gy);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sobel_window_conv.sv
`default_nettype none
// ============================================================================
// Module      : tb_sobel_window_conv
// Description : Self-checking bench for sobel_window_conv (16x8 frames).
//               Frames come from a case table; every result is compared with
//               a frame-array Sobel model, plus hand-written reset and
//               frame-abort sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sobel_window_conv;

    localparam int W = 16;
    localparam int H = 8;

    logic               iCLK = 1'b0;
    logic               iRST;
    logic [11:0]        iDATA;
    logic               iDVAL;
    logic               iFVAL;
    logic signed [14:0] oSobelX;
    logic signed [14:0] oSobelY;
    logic               oDVAL;

    sobel_window_conv #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .iDATA   (iDATA),
        .iDVAL   (iDVAL),
        .iFVAL   (iFVAL),
        .oSobelX (oSobelX),
        .oSobelY (oSobelY),
        .oDVAL   (oDVAL)
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    function automatic void check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Reference model ---------------------------------------------------------
    typedef struct {
        int r;
        int c;
        int gx;
        int gy;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   img [H][W];

    function automatic int pat_pixel(input int pat, input int r, input int c);
        case (pat)
            0:       return 2048;
            1:       return (c < 8) ? 0 : 4095;
            2:       return (c < 8) ? 4095 : 0;
            3:       return (r < 4) ? 0 : 4095;
            default: return int'($urandom_range(0, 4095));
        endcase
    endfunction

    // Sobel on the whole-frame array: window bottom-right is (r,c).
    function automatic void model(input int r, input int c, output int gx, output int gy);
        if (r < 2 || c < 2) begin
            gx = 0;
            gy = 0;
        end else begin
            gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
               - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
            gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c])
               - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
        end
    endfunction

    // Monitor -----------------------------------------------------------------
    logic mon_en   = 1'b0;
    int   n_pulses = 0;
    int   last_x   = 0;
    int   last_y   = 0;
    int   probe_r, probe_c, probe_x, probe_y;

    always @(negedge iCLK) begin
        if (mon_en) begin
            if (oDVAL) begin
                n_pulses++;
                check("dval_expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check($sformatf("gx r%0d c%0d", e.r, e.c), int'(oSobelX), e.gx);
                    check($sformatf("gy r%0d c%0d", e.r, e.c), int'(oSobelY), e.gy);
                    check($sformatf("latency r%0d c%0d", e.r, e.c), cyc, e.cyc);
                    if (e.r == probe_r && e.c == probe_c) begin
                        probe_x = int'(oSobelX);
                        probe_y = int'(oSobelY);
                    end
                end
                last_x = int'(oSobelX);
                last_y = int'(oSobelY);
            end else begin
                check("hold_x", int'(oSobelX), last_x);
                check("hold_y", int'(oSobelY), last_y);
            end
        end
    end

    // Driver ------------------------------------------------------------------
    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    // Drives the first n_pix pixels of a frame; bubbles (random data, iDVAL=0)
    // are inserted before each pixel with probability pct.
    task automatic run_frame(input int pat, input int pct, input int n_pix);
        int gx, gy;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = pat_pixel(pat, r, c);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r * W + c < n_pix) begin
                    for (int g = 0; g < 3; g++) begin
                        if (int'($urandom_range(0, 99)) < pct) begin
                            iFVAL = 1'b1;
                            iDVAL = 1'b0;
                            iDATA = 12'($urandom);
                            step();
                        end
                    end
                    iFVAL = 1'b1;
                    iDVAL = 1'b1;
                    iDATA = 12'(img[r][c]);
                    model(r, c, gx, gy);
                    sb.push_back('{r: r, c: c, gx: gx, gy: gy, cyc: cyc + 2});
                    step();
                end
            end
        end
        iDVAL = 1'b0;
    endtask

    task automatic drain();
        iDVAL = 1'b0;
        iFVAL = 1'b0;
        repeat (4) step();
        check("sb_drained", sb.size(), 0);
    endtask

    task automatic do_reset();
        iDVAL = 1'b0;
        iRST  = 1'b1;
        step();
        // The result still in flight at the reset edge is discarded.
        sb.delete();
        last_x = 0;
        last_y = 0;
        check("post_rst_dval", int'(oDVAL), 0);
        check("post_rst_x", int'(oSobelX), 0);
        check("post_rst_y", int'(oSobelY), 0);
        iRST = 1'b0;
    endtask

    // Case table ----------------------------------------------------------------
    typedef struct {
        int pat;
        int pct;
        int pr;
        int pc;
        int ex;
        int ey;
    } case_t;

    case_t cases [11];

    initial begin
        int p0;
        cases[0]  = '{pat: 0, pct: 0,  pr: 5, pc: 5,  ex: 0,      ey: 0};
        cases[1]  = '{pat: 1, pct: 0,  pr: 2, pc: 8,  ex: 16380,  ey: 0};
        cases[2]  = '{pat: 1, pct: 0,  pr: 3, pc: 9,  ex: 16380,  ey: 0};
        cases[3]  = '{pat: 1, pct: 0,  pr: 4, pc: 10, ex: 0,      ey: 0};
        cases[4]  = '{pat: 2, pct: 0,  pr: 2, pc: 8,  ex: -16380, ey: 0};
        cases[5]  = '{pat: 3, pct: 0,  pr: 4, pc: 5,  ex: 0,      ey: 16380};
        cases[6]  = '{pat: 3, pct: 0,  pr: 5, pc: 2,  ex: 0,      ey: 16380};
        cases[7]  = '{pat: 1, pct: 50, pr: 2, pc: 9,  ex: 16380,  ey: 0};
        cases[8]  = '{pat: 4, pct: 0,  pr: 1, pc: 7,  ex: 0,      ey: 0};
        cases[9]  = '{pat: 4, pct: 30, pr: 6, pc: 1,  ex: 0,      ey: 0};
        cases[10] = '{pat: 2, pct: 50, pr: 6, pc: 9,  ex: -16380, ey: 0};

        probe_r = -1;
        probe_c = -1;
        iRST  = 1'b1;
        iDVAL = 1'b0;
        iFVAL = 1'b0;
        iDATA = '0;
        step();
        step();
        check("rst_dval", int'(oDVAL), 0);
        check("rst_x", int'(oSobelX), 0);
        check("rst_y", int'(oSobelY), 0);
        iRST   = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 11; i++) begin
            probe_r = cases[i].pr;
            probe_c = cases[i].pc;
            probe_x = 99999;
            probe_y = 99999;
            p0 = n_pulses;
            run_frame(cases[i].pat, cases[i].pct, W * H);
            drain();
            check($sformatf("pulses case%0d", i), n_pulses - p0, W * H);
            check($sformatf("probe_x case%0d", i), probe_x, cases[i].ex);
            check($sformatf("probe_y case%0d", i), probe_y, cases[i].ey);
        end
        probe_r = -1;
        probe_c = -1;

        // Reset in the middle of a bubbly random frame, then a fresh frame.
        run_frame(4, 20, 3 * W + 5);
        do_reset();
        p0 = n_pulses;
        run_frame(4, 0, W * H);
        drain();
        check("pulses after_rst", n_pulses - p0, W * H);

        // Frame valid dropped mid-line; in-flight results must still appear.
        p0 = n_pulses;
        run_frame(4, 0, 2 * W + 9);
        drain();
        check("pulses partial", n_pulses - p0, 2 * W + 9);
        p0 = n_pulses;
        run_frame(4, 25, W * H);
        drain();
        check("pulses after_fval_drop", n_pulses - p0, W * H);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
